tt_um_sum_accumulator: RTL and testbench

//   Parametrised, registered successor to the combinational byte adder.

---
 rtl/tt_um_sum_accumulator.sv | 102 ++++++++++
 tb/tb_tt_um_sum_accumulator.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_sum_accumulator.sv
// rtl/tt_um_sum_accumulator.sv - registered multi-channel wrap/saturating adder and accumulator with valid/ready handshake
module tt_um_sum_accumulator #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int GUARD    = 4,
    localparam int ACC_W    = WIDTH + GUARD,
    localparam int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic [1:0]          in_mode,
    input  logic [CH_W-1:0]     in_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_result,
    output logic                out_carry,
    output logic [CH_W-1:0]     out_ch,
    output logic [CHANNELS-1:0] ovf_flags
);

    localparam int SUM_W = WIDTH + 1;
    localparam int NXT_W = ACC_W + 1;

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [ACC_W-1:0] acc [CHANNELS];

    logic             accept;
    logic [SUM_W-1:0] sum;
    logic [NXT_W-1:0] nxt;
    logic [ACC_W-1:0] res_d;
    logic             carry_d;

    // The output register is the only buffer: a new beat may enter only when
    // it is empty or being drained in the same cycle.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum     = {1'b0, in_a} + {1'b0, in_b};
        nxt     = {1'b0, acc[in_ch]} + NXT_W'(in_a);
        res_d   = '0;
        carry_d = 1'b0;
        case (in_mode)
            MODE_WRAP: begin
                res_d   = ACC_W'(sum[WIDTH-1:0]);
                carry_d = sum[WIDTH];
            end
            MODE_SAT: begin
                res_d   = sum[WIDTH] ? ACC_W'({WIDTH{1'b1}}) : ACC_W'(sum[WIDTH-1:0]);
                carry_d = sum[WIDTH];
            end
            MODE_ACC: begin
                res_d   = nxt[ACC_W-1:0];
                carry_d = nxt[ACC_W];
            end
            MODE_LOAD: begin
                res_d   = ACC_W'(in_a);
                carry_d = 1'b0;
            end
            default: begin
                res_d   = '0;
                carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_ch     <= '0;
            ovf_flags  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= res_d;
            out_carry  <= carry_d;
            out_ch     <= in_ch;
            if (in_mode == MODE_ACC) begin
                acc[in_ch]       <= nxt[ACC_W-1:0];
                ovf_flags[in_ch] <= ovf_flags[in_ch] | nxt[ACC_W];
            end else if (in_mode == MODE_LOAD) begin
                acc[in_ch]       <= ACC_W'(in_a);
                ovf_flags[in_ch] <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tt_um_sum_accumulator.sv
// tb/tb_tt_um_sum_accumulator.sv - randomized self-checking bench for tt_um_sum_accumulator
module tb_tt_um_sum_accumulator;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int GUARD    = 4;
    localparam int ACC_W    = WIDTH + GUARD;
    localparam int CH_W     = 2;
    localparam int OP_MAX   = (1 << WIDTH) - 1;
    localparam int ACC_MOD  = 1 << ACC_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a = '0;
    logic [WIDTH-1:0]    in_b = '0;
    logic [1:0]          in_mode = '0;
    logic [CH_W-1:0]     in_ch = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [ACC_W-1:0]    out_result;
    logic                out_carry;
    logic [CH_W-1:0]     out_ch;
    logic [CHANNELS-1:0] ovf_flags;

    int checks = 0;
    int errors = 0;

    int                  m_acc [CHANNELS];
    logic [CHANNELS-1:0] m_ovf;
    int                  exp_res;
    int                  exp_carry;
    int                  exp_ch;
    bit                  exp_valid;

    tt_um_sum_accumulator #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .in_ch      (in_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_ch     (out_ch),
        .ovf_flags  (ovf_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) m_acc[i] = 0;
        m_ovf = '0;
    endtask

    // Reference behaviour straight from the arithmetic rules of each mode.
    task automatic model(input int mode, input int a, input int b, input int ch);
        int s;
        exp_ch = ch;
        case (mode)
            0: begin s = a + b; exp_res = s % (OP_MAX + 1); exp_carry = (s > OP_MAX); end
            1: begin s = a + b; exp_res = (s > OP_MAX) ? OP_MAX : s; exp_carry = (s > OP_MAX); end
            2: begin
                s = m_acc[ch] + a;
                exp_carry = (s >= ACC_MOD);
                m_acc[ch] = s % ACC_MOD;
                exp_res = m_acc[ch];
                if (exp_carry != 0) m_ovf[ch] = 1'b1;
            end
            default: begin m_acc[ch] = a; m_ovf[ch] = 1'b0; exp_res = a; exp_carry = 0; end
        endcase
    endtask

    task automatic beat(input int mode, input int a, input int b, input int ch);
        model(mode, a, b, ch);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_mode   = mode[1:0];
        in_a      = a[WIDTH-1:0];
        in_b      = b[WIDTH-1:0];
        in_ch     = ch[CH_W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, expected 0", in_ready);
        end
        checks++;
        if ({out_valid, out_carry, out_ch, out_result, ovf_flags} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b carry=%0b ch=%0d res=%0d ovf=%b, expected all zero",
                     out_valid, out_carry, out_ch, out_result, ovf_flags);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wrap_add();
        int a, b, ch;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin a = 200; b = 100; end
            else if (i == 1) begin a = 10; b = 20; end
            else begin a = $urandom_range(0, OP_MAX); b = $urandom_range(0, OP_MAX); end
            ch = $urandom_range(0, CHANNELS - 1);
            beat(0, a, b, ch);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_res[ACC_W-1:0] ||
                out_carry !== exp_carry[0] || out_ch !== exp_ch[CH_W-1:0]) begin
                errors++;
                $display("FAIL wrap_add a=%0d b=%0d: valid=%0b res=%0d carry=%0b ch=%0d, expected res=%0d carry=%0d ch=%0d",
                         a, b, out_valid, out_result, out_carry, out_ch, exp_res, exp_carry, exp_ch);
            end
        end
        checks++;
        if (ovf_flags !== m_ovf) begin
            errors++;
            $display("FAIL wrap_add_ovf: got %b, expected %b", ovf_flags, m_ovf);
        end
    endtask

    task automatic test_sat_add();
        int a, b;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin a = 200; b = 100; end
            else if (i == 1) begin a = 255; b = 0; end
            else if (i == 2) begin a = 255; b = 1; end
            else begin a = $urandom_range(0, OP_MAX); b = $urandom_range(0, OP_MAX); end
            beat(1, a, b, i % CHANNELS);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_res[ACC_W-1:0] ||
                out_carry !== exp_carry[0] || out_ch !== exp_ch[CH_W-1:0]) begin
                errors++;
                $display("FAIL sat_add a=%0d b=%0d: valid=%0b res=%0d carry=%0b, expected res=%0d carry=%0d",
                         a, b, out_valid, out_result, out_carry, exp_res, exp_carry);
            end
        end
    endtask

    task automatic test_accumulate();
        beat(3, 0, 0, 2);
        for (int i = 0; i < 17; i++) begin
            beat(2, 255, $urandom_range(0, OP_MAX), 2);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_res[ACC_W-1:0] ||
                out_carry !== exp_carry[0] || out_ch !== 2'd2) begin
                errors++;
                $display("FAIL accumulate step %0d: res=%0d carry=%0b ch=%0d, expected res=%0d carry=%0d ch=2",
                         i, out_result, out_carry, out_ch, exp_res, exp_carry);
            end
            if (i == 15 || i == 16) begin
                checks++;
                if (ovf_flags !== m_ovf) begin
                    errors++;
                    $display("FAIL accumulate_ovf step %0d: got %b, expected %b", i, ovf_flags, m_ovf);
                end
            end
        end
        beat(3, 5, 0, 2);
        checks++;
        if (ovf_flags !== 4'b0000 || out_result !== 12'd5 || out_carry !== 1'b0) begin
            errors++;
            $display("FAIL load_clears: ovf=%b res=%0d carry=%0b, expected ovf=0000 res=5 carry=0",
                     ovf_flags, out_result, out_carry);
        end
    endtask

    task automatic test_stall();
        int held_res, held_carry, held_ch;
        beat(3, 'h50, 0, 1);
        held_res = exp_res; held_carry = exp_carry; held_ch = exp_ch;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b10;
        in_ch     = 2'd1;
        in_a      = 8'h07;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready cycle %0d: got %0b, expected 0", k, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== held_res[ACC_W-1:0] ||
                out_carry !== held_carry[0] || out_ch !== held_ch[CH_W-1:0]) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: valid=%0b res=%0d carry=%0b ch=%0d, expected res=%0d carry=%0d ch=%0d",
                         k, out_valid, out_result, out_carry, out_ch, held_res, held_carry, held_ch);
            end
            @(negedge clk);
            in_a = 8'($urandom); in_b = 8'($urandom);
            in_mode = 2'($urandom); in_ch = 2'($urandom);
        end
        in_mode = 2'b10; in_ch = 2'd1; in_a = 8'h07; in_b = 8'h00;
        out_ready = 1'b1;
        model(2, 7, 0, 1);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 12'h057 || out_carry !== 1'b0 || out_ch !== 2'd1) begin
            errors++;
            $display("FAIL stall_release: valid=%0b res=%0h carry=%0b ch=%0d, expected valid=1 res=57 carry=0 ch=1",
                     out_valid, out_result, out_carry, out_ch);
        end
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_result: out_valid=%0b, expected 0", out_valid);
        end
        for (int c = 0; c < CHANNELS; c++) begin
            beat(2, 0, 0, c);
            checks++;
            if (out_result !== exp_res[ACC_W-1:0]) begin
                errors++;
                $display("FAIL stall_acc ch%0d: got %0d, expected %0d", c, out_result, exp_res);
            end
        end
    endtask

    task automatic test_midstream_reset();
        beat(3, 255, 0, 1);
        beat(2, 'h24, 0, 1);
        checks++;
        if (out_result !== 12'h123) begin
            errors++;
            $display("FAIL preset_ch1: got %0h, expected 123", out_result);
        end
        beat(3, 255, 0, 0);
        for (int i = 0; i < 17; i++) beat(2, 255, 0, 0);
        checks++;
        if (ovf_flags !== m_ovf || m_ovf == '0) begin
            errors++;
            $display("FAIL preset_ovf: got %b, expected %b (nonzero)", ovf_flags, m_ovf);
        end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_mode = 2'b10; in_ch = 2'd1; in_a = 8'h11;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_in_ready: got %0b, expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || ovf_flags !== '0 || out_result !== '0) begin
            errors++;
            $display("FAIL midreset_state: valid=%0b ovf=%b res=%0d, expected 0/0000/0",
                     out_valid, ovf_flags, out_result);
        end
        model_reset();
        model(2, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        in_mode = 2'b10; in_ch = 2'd1; in_a = 8'h00;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 12'd0 || out_ch !== 2'd1) begin
            errors++;
            $display("FAIL midreset_first_beat: valid=%0b res=%0d ch=%0d, expected valid=1 res=0 ch=1",
                     out_valid, out_result, out_ch);
        end
        for (int c = 0; c < CHANNELS; c++) begin
            beat(2, 0, 0, c);
            checks++;
            if (out_result !== 12'd0) begin
                errors++;
                $display("FAIL midreset_acc ch%0d: got %0d, expected 0", c, out_result);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ch;
        for (int i = 0; i < 40; i++) begin
            ch = (i % 2 == 0) ? 0 : 3;
            beat(2, $urandom_range(0, OP_MAX), 0, ch);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_res[ACC_W-1:0] ||
                out_carry !== exp_carry[0] || out_ch !== exp_ch[CH_W-1:0]) begin
                errors++;
                $display("FAIL back_to_back beat %0d ch%0d: res=%0d carry=%0b ch=%0d, expected res=%0d carry=%0d",
                         i, ch, out_result, out_carry, out_ch, exp_res, exp_carry);
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            beat(2, 0, 0, c);
            checks++;
            if (out_result !== exp_res[ACC_W-1:0]) begin
                errors++;
                $display("FAIL back_to_back_total ch%0d: got %0d, expected %0d", c, out_result, exp_res);
            end
        end
        checks++;
        if (ovf_flags !== m_ovf) begin
            errors++;
            $display("FAIL back_to_back_ovf: got %b, expected %b", ovf_flags, m_ovf);
        end
    endtask

    task automatic test_random_backpressure();
        idle();
        exp_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_mode   = 2'($urandom);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_ch     = 2'($urandom);
            #1;
            checks++;
            if (in_ready !== (!exp_valid || out_ready)) begin
                errors++;
                $display("FAIL random_in_ready cycle %0d: got %0b, expected %0b",
                         i, in_ready, (!exp_valid || out_ready));
            end
            if (in_valid && (!exp_valid || out_ready)) begin
                model(int'(in_mode), int'(in_a), int'(in_b), int'(in_ch));
                exp_valid = 1'b1;
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== exp_valid ||
                (exp_valid && (out_result !== exp_res[ACC_W-1:0] || out_carry !== exp_carry[0] ||
                               out_ch !== exp_ch[CH_W-1:0])) ||
                ovf_flags !== m_ovf) begin
                errors++;
                $display("FAIL random cycle %0d: valid=%0b res=%0d carry=%0b ch=%0d ovf=%b, expected valid=%0b res=%0d carry=%0d ch=%0d ovf=%b",
                         i, out_valid, out_result, out_carry, out_ch, ovf_flags,
                         exp_valid, exp_res, exp_carry, exp_ch, m_ovf);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wrap_add();
        test_sat_add();
        test_accumulate();
        test_stall();
        test_midstream_reset();
        test_back_to_back();
        test_random_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
